// File: rtl/mips_fetch_if.sv
// Fetch-to-core instruction handshake: the fetch unit presents one word with
// its byte PC under valid/ready flow control.
interface mips_fetch_if;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (output instruction, instr_valid, instr_pc, input instr_ready);
  modport slave  (input instruction, instr_valid, instr_pc, output instr_ready);
endinterface

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: loadable instruction memory plus byte-addressed PC,
// streaming words to mips_core until the sentinel halt word is reached.
module mips_fetch_unit #(
  parameter int          IMEM_DEPTH = 64,
  parameter int          ADDR_W     = 6,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  mips_fetch_if.master      fetch,
  output logic              halted,
  output logic [15:0]       instr_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t state, state_nxt;

  logic [31:0]       mem [IMEM_DEPTH];
  logic [31:0]       pc;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] word_idx_nxt;
  logic [31:0]       pc_nxt;
  logic [31:0]       fetch_word;
  logic              load_cond;
  logic              hit_halt;
  logic              transfer;

  // The PC only ever holds word-aligned addresses inside the memory, so the
  // increment is done on the word index and wraps naturally at IMEM_DEPTH.
  assign word_idx     = pc[ADDR_W+1:2];
  assign word_idx_nxt = word_idx + ADDR_W'(1);
  assign pc_nxt       = {{(30-ADDR_W){1'b0}}, word_idx_nxt, 2'b00};
  assign fetch_word   = mem[word_idx];

  assign load_cond = (state == RUN) && (!fetch.instr_valid || fetch.instr_ready);
  assign hit_halt  = load_cond && (fetch_word == HALT_WORD);
  assign transfer  = fetch.instr_valid && fetch.instr_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = RUN;
      RUN:     if (hit_halt) state_nxt = HALTED;
      HALTED:  if (start)    state_nxt = RUN;
      default:               state_nxt = IDLE;
    endcase
  end

  // Memory is deliberately outside reset so a program survives it; writes are
  // locked out while running so the stream being fetched cannot change.
  always_ff @(posedge clk) begin
    if (load_en && (state != RUN))
      mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      pc                <= '0;
      fetch.instruction <= '0;
      fetch.instr_valid <= 1'b0;
      fetch.instr_pc    <= '0;
      halted            <= 1'b0;
      instr_count       <= '0;
    end else begin
      state <= state_nxt;
      if (transfer)
        instr_count <= instr_count + 16'd1;
      case (state)
        IDLE: begin
          if (start)
            pc <= '0;
        end
        RUN: begin
          if (load_cond) begin
            if (hit_halt) begin
              fetch.instr_valid <= 1'b0;
              halted            <= 1'b1;
            end else begin
              fetch.instruction <= fetch_word;
              fetch.instr_valid <= 1'b1;
              fetch.instr_pc    <= pc;
              pc                <= pc_nxt;
            end
          end
        end
        HALTED: begin
          if (start) begin
            halted <= 1'b0;
            pc     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: a 64-word instance for program flow and
// a 4-word instance for PC wrap-around.
module tb_mips_fetch_unit;

  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;
  localparam logic [31:0] W_ADD  = 32'h03E1F020;
  localparam logic [31:0] W_ADDU = 32'h00425021;
  localparam logic [31:0] W_AND  = 32'h02084024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, load_en;
  logic [5:0]  load_addr;
  logic [31:0] load_data;
  logic        halted;
  logic [15:0] instr_count;

  logic        w_reset, w_start, w_load_en;
  logic [1:0]  w_load_addr;
  logic [31:0] w_load_data;
  logic        w_halted;
  logic [15:0] w_instr_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  mips_fetch_if f_if ();
  mips_fetch_if w_if ();

  mips_fetch_unit #(.IMEM_DEPTH(64), .ADDR_W(6), .HALT_WORD(HALT)) dut (
    .clk(clk), .reset(reset), .start(start), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .fetch(f_if),
    .halted(halted), .instr_count(instr_count)
  );

  mips_fetch_unit #(.IMEM_DEPTH(4), .ADDR_W(2), .HALT_WORD(HALT)) dut_w (
    .clk(clk), .reset(w_reset), .start(w_start), .load_en(w_load_en),
    .load_addr(w_load_addr), .load_data(w_load_data), .fetch(w_if),
    .halted(w_halted), .instr_count(w_instr_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_word(input logic [5:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (f_if.instr_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", f_if.instr_valid);
    else pass_cnt++;
    total_cnt++;
    if (f_if.instr_pc !== 32'd0) $display("FAIL reset_pc got %h want 0", f_if.instr_pc);
    else pass_cnt++;
    total_cnt++;
    if (f_if.instruction !== 32'd0) $display("FAIL reset_instr got %h want 0", f_if.instruction);
    else pass_cnt++;
    total_cnt++;
    if (halted !== 1'b0 || instr_count !== 16'd0)
      $display("FAIL reset_status got halted=%b count=%0d want 0/0", halted, instr_count);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    do_reset();
    load_word(6'd0, W_ADD);
    load_word(6'd1, W_ADDU);
    load_word(6'd2, HALT);
    f_if.instr_ready = 1'b1;
    pulse_start();
    total_cnt++;
    if (f_if.instr_valid !== 1'b0) $display("FAIL basic_latency got valid=%b want 0", f_if.instr_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (f_if.instr_valid !== 1'b1 || f_if.instruction !== W_ADD || f_if.instr_pc !== 32'd0)
      $display("FAIL basic_first got v=%b i=%h pc=%h want 1/%h/0", f_if.instr_valid, f_if.instruction, f_if.instr_pc, W_ADD);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (f_if.instr_valid !== 1'b1 || f_if.instruction !== W_ADDU || f_if.instr_pc !== 32'd4)
      $display("FAIL basic_second got v=%b i=%h pc=%h want 1/%h/4", f_if.instr_valid, f_if.instruction, f_if.instr_pc, W_ADDU);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (f_if.instr_valid !== 1'b0 || halted !== 1'b1 || instr_count !== 16'd2)
      $display("FAIL basic_halt got v=%b h=%b cnt=%0d want 0/1/2", f_if.instr_valid, halted, instr_count);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    f_if.instr_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (f_if.instr_valid !== 1'b1 || f_if.instruction !== W_ADD || f_if.instr_pc !== 32'd0)
        $display("FAIL bp_hold%0d got v=%b i=%h pc=%h want 1/%h/0", i, f_if.instr_valid, f_if.instruction, f_if.instr_pc, W_ADD);
      else pass_cnt++;
    end
    total_cnt++;
    if (instr_count !== 16'd0) $display("FAIL bp_nocount got %0d want 0", instr_count);
    else pass_cnt++;
    f_if.instr_ready = 1'b1;
    tick();
    total_cnt++;
    if (f_if.instruction !== W_ADDU || f_if.instr_pc !== 32'd4 || instr_count !== 16'd1)
      $display("FAIL bp_second got i=%h pc=%h cnt=%0d want %h/4/1", f_if.instruction, f_if.instr_pc, instr_count, W_ADDU);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (halted !== 1'b1 || f_if.instr_valid !== 1'b0 || instr_count !== 16'd2)
      $display("FAIL bp_end got h=%b v=%b cnt=%0d want 1/0/2", halted, f_if.instr_valid, instr_count);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [6];
    exp_pc = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd0, 32'd4};
    w_reset = 1'b1;
    tick();
    w_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_load_en = 1'b1; w_load_addr = 2'(i); w_load_data = 32'h0000_1000 + 32'(i);
      tick();
    end
    w_load_en = 1'b0;
    w_if.instr_ready = 1'b1;
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      total_cnt++;
      if (w_if.instr_valid !== 1'b1 || w_if.instr_pc !== exp_pc[k] || w_instr_count !== 16'(k)
          || w_if.instruction !== 32'h0000_1000 + (exp_pc[k] >> 2))
        $display("FAIL wrap%0d got v=%b pc=%0d i=%h cnt=%0d want 1/%0d/%h/%0d", k, w_if.instr_valid,
                 w_if.instr_pc, w_if.instruction, w_instr_count, exp_pc[k], 32'h0000_1000 + (exp_pc[k] >> 2), k);
      else pass_cnt++;
    end
    w_reset = 1'b1;
    tick();
    w_reset = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    f_if.instr_ready = 1'b1;
    pulse_start();
    tick();
    tick();
    total_cnt++;
    if (f_if.instr_valid !== 1'b1 || f_if.instr_pc !== 32'd4)
      $display("FAIL midrst_pre got v=%b pc=%h want 1/4", f_if.instr_valid, f_if.instr_pc);
    else pass_cnt++;
    do_reset();
    total_cnt++;
    if (f_if.instr_valid !== 1'b0 || f_if.instr_pc !== 32'd0 || instr_count !== 16'd0)
      $display("FAIL midrst_post got v=%b pc=%h cnt=%0d want 0/0/0", f_if.instr_valid, f_if.instr_pc, instr_count);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (f_if.instr_valid !== 1'b0) $display("FAIL midrst_idle got v=%b want 0", f_if.instr_valid);
    else pass_cnt++;
    pulse_start();
    tick();
    total_cnt++;
    if (f_if.instr_valid !== 1'b1 || f_if.instruction !== W_ADD || f_if.instr_pc !== 32'd0)
      $display("FAIL midrst_refetch got v=%b i=%h pc=%h want 1/%h/0", f_if.instr_valid, f_if.instruction, f_if.instr_pc, W_ADD);
    else pass_cnt++;
    do_reset();
  endtask

  task automatic test_load_gating();
    do_reset();
    f_if.instr_ready = 1'b0;
    pulse_start();
    load_word(6'd0, W_AND);
    total_cnt++;
    if (f_if.instruction !== W_ADD) $display("FAIL gate_run_fetch got %h want %h", f_if.instruction, W_ADD);
    else pass_cnt++;
    f_if.instr_ready = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (halted !== 1'b1) $display("FAIL gate_halt1 got %b want 1", halted);
    else pass_cnt++;
    pulse_start();
    tick();
    total_cnt++;
    if (f_if.instruction !== W_ADD || f_if.instr_valid !== 1'b1)
      $display("FAIL gate_run_ignored got i=%h v=%b want %h/1", f_if.instruction, f_if.instr_valid, W_ADD);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (halted !== 1'b1 || instr_count !== 16'd4)
      $display("FAIL gate_halt2 got h=%b cnt=%0d want 1/4", halted, instr_count);
    else pass_cnt++;
    load_word(6'd0, W_AND);
    pulse_start();
    total_cnt++;
    if (halted !== 1'b0) $display("FAIL gate_restart_clr got %b want 0", halted);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (f_if.instruction !== W_AND || f_if.instr_pc !== 32'd0 || instr_count !== 16'd4)
      $display("FAIL gate_halted_load got i=%h pc=%h cnt=%0d want %h/0/4", f_if.instruction, f_if.instr_pc, instr_count, W_AND);
    else pass_cnt++;
    do_reset();
  endtask

  task automatic test_edges();
    do_reset();
    f_if.instr_ready = 1'b1;
    load_word(6'd0, HALT);
    pulse_start();
    tick();
    total_cnt++;
    if (halted !== 1'b1 || f_if.instr_valid !== 1'b0 || instr_count !== 16'd0)
      $display("FAIL empty_prog got h=%b v=%b cnt=%0d want 1/0/0", halted, f_if.instr_valid, instr_count);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (f_if.instr_valid !== 1'b0) $display("FAIL empty_novalid got %b want 0", f_if.instr_valid);
    else pass_cnt++;
    do_reset();
    start = 1'b1; load_en = 1'b1; load_addr = 6'd0; load_data = W_ADD;
    tick();
    start = 1'b0; load_en = 1'b0;
    tick();
    total_cnt++;
    if (f_if.instr_valid !== 1'b1 || f_if.instruction !== W_ADD || f_if.instr_pc !== 32'd0)
      $display("FAIL start_load got v=%b i=%h pc=%h want 1/%h/0", f_if.instr_valid, f_if.instruction, f_if.instr_pc, W_ADD);
    else pass_cnt++;
    do_reset();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    w_reset = 1'b1; w_start = 1'b0; w_load_en = 1'b0; w_load_addr = '0; w_load_data = '0;
    f_if.instr_ready = 1'b0;
    w_if.instr_ready = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_reset_mid_run();
    test_load_gating();
    test_edges();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
